// File: rtl/change_dispenser_if.sv
// rtl/change_dispenser_if.sv - request/hopper/status signal bundle for change_dispenser
//   start, amount, clr  : payout request and error clear (master -> slave)
//   coin_ack            : hopper acknowledge, 4-phase (master -> slave)
//   coin_req, coin_sel  : hopper coin request and coin type (slave -> master)
//   busy, done, error   : status (slave -> master)
//   remaining           : value still owed (slave -> master)
interface change_dispenser_if;
    logic       start;
    logic [7:0] amount;
    logic       clr;
    logic       coin_ack;
    logic       coin_req;
    logic [1:0] coin_sel;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] remaining;

    modport master (
        output start, amount, clr, coin_ack,
        input  coin_req, coin_sel, busy, done, error, remaining
    );

    modport slave (
        input  start, amount, clr, coin_ack,
        output coin_req, coin_sel, busy, done, error, remaining
    );
endinterface

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy coin change dispenser with 4-phase hopper handshake
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : change_dispenser_if.slave (start/amount/clr/coin_ack in,
//         coin_req/coin_sel/busy/done/error/remaining out)
//   Parameters: DENOM_HI (large coin), DENOM_MID (medium coin), TIMEOUT (cycles per ack edge)
//   Optional: define CHANGE_DISPENSER_TIMEOUT_EN to enable the handshake watchdog and ERR path.
module change_dispenser #(
    parameter int DENOM_HI  = 10,
    parameter int DENOM_MID = 5,
    parameter int TIMEOUT   = 1000
) (
    input  logic               clk,
    input  logic               rst,
    change_dispenser_if.slave  bus
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SELECT  = 3'd1;
    localparam logic [2:0] REQ     = 3'd2;
    localparam logic [2:0] RELEASE = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;
    localparam logic [2:0] ERR     = 3'd5;

    localparam logic [7:0] VAL_HI  = 8'(DENOM_HI);
    localparam logic [7:0] VAL_MID = 8'(DENOM_MID);

    logic [2:0] state;
    logic [1:0] sel_q;
    logic [7:0] rem_q;
    logic [1:0] next_sel;
    logic [7:0] coin_val;
    logic       timeout_hit;

    // Greedy choice: largest coin not exceeding what is still owed.
    always_comb begin
        next_sel = 2'b01;
        if (rem_q >= VAL_HI)
            next_sel = 2'b11;
        else if (rem_q >= VAL_MID)
            next_sel = 2'b10;
    end

    always_comb begin
        case (sel_q)
            2'b11:   coin_val = VAL_HI;
            2'b10:   coin_val = VAL_MID;
            2'b01:   coin_val = 8'd1;
            default: coin_val = 8'd0;
        endcase
    end

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    // REQ is only entered from SELECT and RELEASE only from an acked REQ,
    // so clearing in those two places covers every entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tmo_cnt <= '0;
        else if (state == SELECT || (state == REQ && bus.coin_ack))
            tmo_cnt <= '0;
        else if (state == REQ || state == RELEASE)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Fires on the TIMEOUT-th cycle spent waiting for the awaited ack level.
    assign timeout_hit = (tmo_cnt == TW'(TIMEOUT - 1));
    assign bus.error   = (state == ERR);
`else
    localparam int unused_timeout = TIMEOUT;
    assign timeout_hit = 1'b0;
    assign bus.error   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sel_q <= 2'b00;
            rem_q <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rem_q <= bus.amount;
                        state <= SELECT;
                    end
                end
                SELECT: begin
                    if (rem_q == 8'd0) begin
                        state <= DONE;
                    end else begin
                        sel_q <= next_sel;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.coin_ack) begin
                        rem_q <= rem_q - coin_val;
                        state <= RELEASE;
                    end else if (timeout_hit) begin
                        sel_q <= 2'b00;
                        state <= ERR;
                    end
                end
                RELEASE: begin
                    if (!bus.coin_ack) begin
                        sel_q <= 2'b00;
                        state <= SELECT;
                    end else if (timeout_hit) begin
                        sel_q <= 2'b00;
                        state <= ERR;
                    end
                end
                DONE: state <= IDLE;
                ERR: begin
                    if (bus.clr)
                        state <= IDLE;
                end
                default: begin
                    sel_q <= 2'b00;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.coin_req  = (state == REQ);
    assign bus.coin_sel  = sel_q;
    assign bus.busy      = (state == SELECT) || (state == REQ) || (state == RELEASE);
    assign bus.done      = (state == DONE);
    assign bus.remaining = rem_q;

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed self-checking bench for change_dispenser
module tb_change_dispenser;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   sel_log[$];
    int   rem_log[$];
    int   stab_err;

    change_dispenser_if bus ();

    change_dispenser #(
        .DENOM_HI  (10),
        .DENOM_MID (5),
        .TIMEOUT   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] amt);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.amount = amt;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    // Hopper model: acks each request after `delay` extra cycles, drops ack once req falls.
    task automatic serve(input int delay, input int budget, output int got_done);
        int wcnt;
        int last_rem;
        int cyc;
        logic prev_req;
        logic [1:0] prev_sel;
        sel_log.delete();
        rem_log.delete();
        wcnt = 0; got_done = 0; cyc = 0; last_rem = -1;
        stab_err = 0; prev_req = 1'b0; prev_sel = 2'b00;
        while (got_done == 0 && cyc < budget) begin
            if (int'(bus.remaining) != last_rem) begin
                last_rem = int'(bus.remaining);
                rem_log.push_back(last_rem);
            end
            if (bus.done) got_done = 1;
            if (bus.coin_req && prev_req && bus.coin_sel != prev_sel) stab_err++;
            prev_req = bus.coin_req;
            prev_sel = bus.coin_sel;
            if (bus.coin_req && !bus.coin_ack) begin
                if (wcnt >= delay) begin
                    bus.coin_ack = 1'b1;
                    sel_log.push_back(int'(bus.coin_sel));
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else if (!bus.coin_req && bus.coin_ack) begin
                bus.coin_ack = 1'b0;
            end
            if (got_done == 0) begin
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    initial begin
        int got_done;
        int n11, n10, n01, nreq;
        int exp_sel1[4];
        int exp_rem1[5];
        int exp_sel4[3];
        exp_sel1 = '{3, 2, 1, 1};
        exp_rem1 = '{17, 7, 2, 1, 0};
        exp_sel4 = '{3, 2, 1};
        n_cmp = 0; n_err = 0;
        rst = 1'b0;
        bus.start = 1'b0; bus.amount = 8'd0; bus.clr = 1'b0; bus.coin_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_coin_req", bus.coin_req, 0);
        check_eq("rst_coin_sel", bus.coin_sel, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_error", bus.error, 0);
        check_eq("rst_remaining", bus.remaining, 0);
        rst = 1'b1;

        // amount 17, ack after 3 cycles
        do_start(8'd17);
        serve(3, 500, got_done);
        check_eq("t17_done", got_done, 1);
        check_eq("t17_nsel", sel_log.size(), 4);
        for (int i = 0; i < 4 && i < sel_log.size(); i++) check_eq("t17_sel", sel_log[i], exp_sel1[i]);
        check_eq("t17_nrem", rem_log.size(), 5);
        for (int i = 0; i < 5 && i < rem_log.size(); i++) check_eq("t17_rem", rem_log[i], exp_rem1[i]);
        check_eq("t17_sel_stable", stab_err, 0);
        @(negedge clk);
        check_eq("t17_done_once", bus.done, 0);
        check_eq("t17_idle_busy", bus.busy, 0);

        // amount 0
        do_start(8'd0);
        check_eq("t0_busy_c1", bus.busy, 1);
        check_eq("t0_done_c1", bus.done, 0);
        check_eq("t0_req_c1", bus.coin_req, 0);
        @(negedge clk);
        check_eq("t0_done_c2", bus.done, 1);
        check_eq("t0_busy_c2", bus.busy, 0);
        check_eq("t0_req_c2", bus.coin_req, 0);
        @(negedge clk);
        check_eq("t0_done_c3", bus.done, 0);

        // amount 255, immediate ack
        do_start(8'd255);
        serve(0, 3000, got_done);
        check_eq("t255_done", got_done, 1);
        n11 = 0; n10 = 0; n01 = 0;
        foreach (sel_log[i]) begin
            if (sel_log[i] == 3) n11++;
            else if (sel_log[i] == 2) n10++;
            else if (sel_log[i] == 1) n01++;
        end
        check_eq("t255_n11", n11, 25);
        check_eq("t255_n10", n10, 1);
        check_eq("t255_n01", n01, 0);
        check_eq("t255_remaining", bus.remaining, 0);

        // amount 16 with a stray start of 9 while busy
        do_start(8'd16);
        fork
            serve(2, 500, got_done);
            begin
                repeat (4) @(negedge clk);
                bus.start = 1'b1; bus.amount = 8'd9;
                @(negedge clk);
                bus.start = 1'b0;
            end
        join
        check_eq("t16_done", got_done, 1);
        check_eq("t16_nsel", sel_log.size(), 3);
        for (int i = 0; i < 3 && i < sel_log.size(); i++) check_eq("t16_sel", sel_log[i], exp_sel4[i]);
        @(negedge clk);
        check_eq("t16_idle", bus.busy, 0);

        // reset in the middle of amount 6
        do_start(8'd6);
        nreq = 0;
        while (!bus.coin_req && nreq < 20) begin @(negedge clk); nreq++; end
        check_eq("t6_req_seen", bus.coin_req, 1);
        #2 rst = 1'b0;
        #1;
        check_eq("t6_async_req", bus.coin_req, 0);
        check_eq("t6_async_sel", bus.coin_sel, 0);
        check_eq("t6_async_rem", bus.remaining, 0);
        check_eq("t6_async_busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b1;
        nreq = 0;
        repeat (20) begin @(negedge clk); if (bus.coin_req) nreq++; end
        check_eq("t6_no_req_after", nreq, 0);

        // stalled hopper on amount 3
        do_start(8'd3);
        nreq = 0;
        while (!bus.coin_req && nreq < 20) begin @(negedge clk); nreq++; end
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
        nreq = 0;
        while (bus.coin_req && nreq < 100) begin nreq++; @(negedge clk); end
        check_eq("tmo_req_cycles", nreq, 8);
        check_eq("tmo_error", bus.error, 1);
        check_eq("tmo_coin_req", bus.coin_req, 0);
        check_eq("tmo_coin_sel", bus.coin_sel, 0);
        check_eq("tmo_busy", bus.busy, 0);
        check_eq("tmo_remaining", bus.remaining, 3);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        check_eq("tmo_clr_error", bus.error, 0);
        check_eq("tmo_clr_busy", bus.busy, 0);
`else
        repeat (20) @(negedge clk);
        check_eq("wait_coin_req", bus.coin_req, 1);
        check_eq("wait_coin_sel", bus.coin_sel, 1);
        check_eq("wait_error", bus.error, 0);
        check_eq("wait_busy", bus.busy, 1);
        serve(1, 200, got_done);
        check_eq("wait_done", got_done, 1);
        check_eq("wait_remaining", bus.remaining, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
